// File: rtl/counter_seq_pkg.sv
// Shared encodings for the counter sequencer: FSM state codes and program modes.
package counter_seq_pkg;

  typedef logic [2:0] state_t;
  typedef logic [1:0] mode_t;

  localparam state_t IDLE     = 3'd0;
  localparam state_t LOAD     = 3'd1;
  localparam state_t RUN_UP   = 3'd2;
  localparam state_t RUN_DOWN = 3'd3;
  localparam state_t DONE     = 3'd4;

  localparam mode_t MODE_UP       = 2'd0;
  localparam mode_t MODE_DOWN     = 2'd1;
  localparam mode_t MODE_PINGPONG = 2'd2;
  localparam mode_t MODE_WRAP     = 2'd3;

endpackage

// File: rtl/counter.sv
// Up/down mod-M counter with clear, load and enable; clear beats load beats count.
module counter #(
  parameter int N = 8,
  parameter int M = 163
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic         max_tick,
  output logic         min_tick
);

  localparam logic [N-1:0] TERM = N'(M - 1);

  logic [N-1:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d;
    end else if (en) begin
      if (up) begin
        r_q <= (r_q == TERM) ? '0 : r_q + N'(1);
      end else begin
        r_q <= (r_q == '0) ? TERM : r_q - N'(1);
      end
    end
  end

  assign q        = r_q;
  assign max_tick = (r_q == TERM);
  assign min_tick = (r_q == '0);

endmodule

// File: rtl/counter_seq_ctrl.sv
// Program sequencer for the mod-M counter: one-shot up/down, ping-pong, wrap-repeat.
// Optional macro COUNTER_SEQ_AUTOCLR_EN clears the counter during the DONE cycle.
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int N  = 8,
  parameter int M  = 163,
  parameter int RW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [1:0]    mode,
  input  logic [N-1:0]  preset,
  input  logic [RW-1:0] reps,
  input  logic          max_tick,
  input  logic          min_tick,
  output logic          clr,
  output logic          load,
  output logic          en,
  output logic          up,
  output logic [N-1:0]  d,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] rep_cnt
);

  localparam logic [N:0]    M_EXT   = (N+1)'(M);
  localparam logic [N-1:0]  TERM    = N'(M - 1);
  localparam logic [RW-1:0] REP_MAX = '1;

  state_t        r_state;
  state_t        w_state_next;
  mode_t         r_mode;
  logic [N-1:0]  r_preset;
  logic [RW-1:0] r_reps;
  logic [RW-1:0] r_rep_cnt;
  logic [RW-1:0] w_rep_cnt_next;
  logic [RW-1:0] w_rep_inc;
  logic          w_accept;
  logic          w_last;
  logic          w_hold;

  assign w_accept  = (r_state == IDLE) && start && !stop;
  assign w_rep_inc = (r_rep_cnt == REP_MAX) ? r_rep_cnt : r_rep_cnt + RW'(1);
  assign w_last    = (({1'b0, r_rep_cnt} + (RW+1)'(1)) == {1'b0, r_reps});

  always_comb begin
    w_state_next   = r_state;
    w_rep_cnt_next = r_rep_cnt;
    w_hold         = 1'b0;
    load           = 1'b0;
    up             = 1'b0;
    done           = 1'b0;
    d              = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next   = LOAD;
          w_rep_cnt_next = '0;
        end
      end
      LOAD: begin
        load = 1'b1;
        d    = r_preset;
        if (stop)                      w_state_next = IDLE;
        else if (r_mode == MODE_DOWN)  w_state_next = RUN_DOWN;
        else                           w_state_next = RUN_UP;
      end
      RUN_UP: begin
        up = 1'b1;
        if (stop) begin
          w_state_next = IDLE;
        end else if (max_tick) begin
          case (r_mode)
            MODE_PINGPONG: begin
              w_hold       = 1'b1;
              w_state_next = RUN_DOWN;
            end
            // wrap-repeat lets the counter roll over except on the final pass
            MODE_WRAP: begin
              w_rep_cnt_next = w_rep_inc;
              if (w_last) begin
                w_hold       = 1'b1;
                w_state_next = DONE;
              end
            end
            default: begin
              w_hold         = 1'b1;
              w_rep_cnt_next = RW'(1);
              w_state_next   = DONE;
            end
          endcase
        end
      end
      RUN_DOWN: begin
        if (stop) begin
          w_state_next = IDLE;
        end else if (min_tick) begin
          w_hold = 1'b1;
          if (r_mode == MODE_PINGPONG) begin
            w_rep_cnt_next = w_rep_inc;
            w_state_next   = w_last ? DONE : RUN_UP;
          end else begin
            w_rep_cnt_next = RW'(1);
            w_state_next   = DONE;
          end
        end
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign en      = ((r_state == RUN_UP) || (r_state == RUN_DOWN)) && !stop && !w_hold;
  assign busy    = (r_state != IDLE);
  assign rep_cnt = r_rep_cnt;

`ifdef COUNTER_SEQ_AUTOCLR_EN
  assign clr = (r_state == DONE);
`else
  assign clr = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_rep_cnt <= '0;
      r_mode    <= MODE_UP;
      r_preset  <= '0;
      r_reps    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_rep_cnt <= w_rep_cnt_next;
      if (w_accept) begin
        r_mode   <= mode;
        r_preset <= ({1'b0, preset} >= M_EXT) ? TERM : preset;
        r_reps   <= (reps == '0) ? RW'(1) : reps;
      end
    end
  end

endmodule
